// File: rtl/lzrw_sequencer.sv
// LZRW1 compression control sequencer.
// Walks the input one item at a time and emits literal/copy items plus control words.
module lzrw_sequencer #(
   parameter int STRINGSIZE = 4096,
   parameter int MINMATCH   = 3
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_start,
   input  logic [$clog2(STRINGSIZE):0]       i_src_len,
   output logic [$clog2(STRINGSIZE)-1:0]     o_pos,
   output logic                              o_hash_en,
   input  logic                              i_tbl_rd_valid,
   input  logic                              i_tbl_hit,
   input  logic [3:0]                        i_cmp_len,
   output logic                              o_tbl_wr,
   output logic                              o_emit_valid,
   input  logic                              i_emit_ready,
   output logic                              o_emit_is_copy,
   output logic [3:0]                        o_emit_len,
   output logic                              o_ctrl_valid,
   input  logic                              i_ctrl_ready,
   output logic [15:0]                       o_ctrl_word,
   output logic                              o_busy,
   output logic                              o_done
);

   localparam int LW = $clog2(STRINGSIZE) + 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOOKUP  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_DECIDE  = 3'd3;
   localparam logic [2:0] S_EMIT    = 3'd4;
   localparam logic [2:0] S_ADVANCE = 3'd5;
   localparam logic [2:0] S_FLUSH   = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic [2:0]    r_state;
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_pos;
   logic [3:0]    r_cnt;
   logic          r_hit;
   logic          r_looked;
   logic          r_is_copy;
   logic [3:0]    r_elen;
   logic [15:0]   r_ctrl;
   logic          r_busy;
   logic          r_done;

   logic [LW-1:0] w_rem;
   logic          w_short;
   logic [3:0]    w_clamp;
   logic          w_copy;
   logic [LW-1:0] w_step;
   logic [LW-1:0] w_pos_nx;
   logic [3:0]    w_cnt_nx;
   logic          w_start_ok;

   // Remaining bytes, clamped match length and next-position arithmetic.
   always_comb begin
      w_rem      = r_len - r_pos;
      w_short    = (w_rem < LW'(MINMATCH));
      w_clamp    = (w_rem < {{(LW-4){1'b0}}, i_cmp_len}) ? w_rem[3:0] : i_cmp_len;
      w_copy     = r_hit && (w_clamp >= 4'(MINMATCH));
      w_step     = r_is_copy ? {{(LW-4){1'b0}}, r_elen} : LW'(1);
      w_pos_nx   = r_pos + w_step;
      w_cnt_nx   = r_cnt + 4'd1;
      w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   end

   // Strobes and valids decode straight from state so reset clears them at once.
   always_comb begin
      o_pos          = r_pos[LW-2:0];
      o_hash_en      = (r_state == S_LOOKUP) && !w_short;
      o_tbl_wr       = (r_state == S_EMIT) && i_emit_ready && r_looked;
      o_emit_valid   = (r_state == S_EMIT);
      o_emit_is_copy = r_is_copy;
      o_emit_len     = r_elen;
      o_ctrl_valid   = (r_state == S_FLUSH);
      o_ctrl_word    = r_ctrl;
      o_busy         = r_busy;
      o_done         = r_done;
   end

   // Main sequencing FSM: lookup, decide, emit, advance, flush.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_pos     <= '0;
         r_cnt     <= '0;
         r_hit     <= 1'b0;
         r_looked  <= 1'b0;
         r_is_copy <= 1'b0;
         r_elen    <= '0;
         r_ctrl    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  r_len  <= i_src_len;
                  r_pos  <= '0;
                  r_cnt  <= '0;
                  r_ctrl <= '0;
                  if (i_src_len == '0) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end else begin
                     r_done  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= S_LOOKUP;
                  end
               end
            end
            S_LOOKUP: begin
               if (w_short) begin
                  r_looked  <= 1'b0;
                  r_is_copy <= 1'b0;
                  r_elen    <= '0;
                  r_state   <= S_EMIT;
               end else begin
                  r_looked <= 1'b1;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_tbl_rd_valid) begin
                  r_hit   <= i_tbl_hit;
                  r_state <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               r_is_copy <= w_copy;
               r_elen    <= w_copy ? w_clamp : 4'd0;
               r_state   <= S_EMIT;
            end
            S_EMIT: begin
               if (i_emit_ready) begin
                  r_ctrl[r_cnt] <= r_is_copy;
                  r_state       <= S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               r_pos <= w_pos_nx;
               r_cnt <= w_cnt_nx;
               if ((w_cnt_nx == 4'd0) || (w_pos_nx == r_len)) begin
                  r_state <= S_FLUSH;
               end else begin
                  r_state <= S_LOOKUP;
               end
            end
            S_FLUSH: begin
               if (i_ctrl_ready) begin
                  r_ctrl <= '0;
                  if (r_pos == r_len) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_LOOKUP;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lzrw_sequencer.sv
// Directed self-checking bench for lzrw_sequencer.
// Background table responder and handshake monitor; checks in one linear sequence.
module tb_lzrw_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [12:0] src_len;
   logic [11:0] pos;
   logic        hash_en;
   logic        tbl_rd_valid;
   logic        tbl_hit;
   logic [3:0]  cmp_len;
   logic        tbl_wr;
   logic        emit_valid;
   logic        emit_ready;
   logic        emit_is_copy;
   logic [3:0]  emit_len;
   logic        ctrl_valid;
   logic        ctrl_ready;
   logic [15:0] ctrl_word;
   logic        busy;
   logic        done;

   lzrw_sequencer dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_src_len      (src_len),
      .o_pos          (pos),
      .o_hash_en      (hash_en),
      .i_tbl_rd_valid (tbl_rd_valid),
      .i_tbl_hit      (tbl_hit),
      .i_cmp_len      (cmp_len),
      .o_tbl_wr       (tbl_wr),
      .o_emit_valid   (emit_valid),
      .i_emit_ready   (emit_ready),
      .o_emit_is_copy (emit_is_copy),
      .o_emit_len     (emit_len),
      .o_ctrl_valid   (ctrl_valid),
      .i_ctrl_ready   (ctrl_ready),
      .o_ctrl_word    (ctrl_word),
      .o_busy         (busy),
      .o_done         (done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic       hit_tab [0:31];
   logic [3:0] len_tab [0:31];
   int         lat = 0;

   int          n_emit, n_ctrl, n_hash, n_wr;
   logic [11:0] e_pos  [0:31];
   logic        e_copy [0:31];
   logic [3:0]  e_len  [0:31];
   logic [15:0] c_word [0:3];
   int          c_at   [0:3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      n_emit = 0;
      n_ctrl = 0;
      n_hash = 0;
      n_wr   = 0;
      for (int i = 0; i < 32; i++) begin
         hit_tab[i] = 1'b0;
         len_tab[i] = 4'd0;
      end
   endtask

   task automatic start_job(input logic [12:0] len);
      @(posedge clk); #1;
      src_len = len;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_emit_valid(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (emit_valid) break;
      end
      chk(tag, {31'd0, emit_valid}, 32'd1);
   endtask

   // Table model: result one cycle after the lookup (plus lat), length the cycle after.
   initial begin
      logic [4:0] p;
      tbl_rd_valid = 1'b0;
      tbl_hit      = 1'b0;
      cmp_len      = 4'd0;
      forever begin
         @(negedge clk);
         if (hash_en) begin
            p = pos[4:0];
            @(posedge clk); #1;
            repeat (lat) begin
               @(posedge clk); #1;
            end
            tbl_rd_valid = 1'b1;
            tbl_hit      = hit_tab[p];
            @(posedge clk); #1;
            tbl_rd_valid = 1'b0;
            tbl_hit      = 1'b0;
            cmp_len      = len_tab[p];
            @(posedge clk); #1;
            cmp_len      = 4'd0;
         end
      end
   end

   // Handshake monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (emit_valid && emit_ready) begin
               if (n_emit < 32) begin
                  e_pos[n_emit]  = pos;
                  e_copy[n_emit] = emit_is_copy;
                  e_len[n_emit]  = emit_len;
               end
               n_emit++;
            end
            if (ctrl_valid && ctrl_ready) begin
               if (n_ctrl < 4) begin
                  c_word[n_ctrl] = ctrl_word;
                  c_at[n_ctrl]   = n_emit;
               end
               n_ctrl++;
            end
            if (hash_en) n_hash++;
            if (tbl_wr) n_wr++;
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      src_len    = 13'd0;
      emit_ready = 1'b1;
      ctrl_ready = 1'b1;
      clear_logs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pos", {20'd0, pos}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_emit_valid", {31'd0, emit_valid}, 32'd0);
      chk("rst_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
      chk("rst_hash_en", {31'd0, hash_en}, 32'd0);
      chk("rst_ctrl_word", {16'd0, ctrl_word}, 32'd0);
      chk("rst_emit_len", {28'd0, emit_len}, 32'd0);
      rst_n = 1'b1;

      // Five literals, last two without lookup.
      clear_logs();
      start_job(13'd5);
      wait_done("t1_done");
      chk("t1_n_emit", n_emit, 5);
      for (int i = 0; i < 5; i++) begin
         chk("t1_e_pos", {20'd0, e_pos[i]}, i);
         chk("t1_e_copy", {31'd0, e_copy[i]}, 32'd0);
      end
      chk("t1_n_hash", n_hash, 3);
      chk("t1_n_wr", n_wr, 3);
      chk("t1_n_ctrl", n_ctrl, 1);
      chk("t1_ctrl_word", {16'd0, c_word[0]}, 32'h0000);
      chk("t1_busy", {31'd0, busy}, 32'd0);
      chk("t1_end_pos", {20'd0, pos}, 32'd5);

      // Copy of 6 at pos 0 with slow table, then two tail literals.
      clear_logs();
      hit_tab[0] = 1'b1;
      len_tab[0] = 4'd6;
      lat = 2;
      start_job(13'd8);
      wait_done("t2_done");
      lat = 0;
      chk("t2_n_emit", n_emit, 3);
      chk("t2_pos0", {20'd0, e_pos[0]}, 32'd0);
      chk("t2_copy0", {31'd0, e_copy[0]}, 32'd1);
      chk("t2_len0", {28'd0, e_len[0]}, 32'd6);
      chk("t2_pos1", {20'd0, e_pos[1]}, 32'd6);
      chk("t2_copy1", {31'd0, e_copy[1]}, 32'd0);
      chk("t2_len1", {28'd0, e_len[1]}, 32'd0);
      chk("t2_pos2", {20'd0, e_pos[2]}, 32'd7);
      chk("t2_n_hash", n_hash, 1);
      chk("t2_n_wr", n_wr, 1);
      chk("t2_ctrl_word", {16'd0, c_word[0]}, 32'h0001);

      // Short hit is a literal; long match clamped to remaining.
      clear_logs();
      hit_tab[0] = 1'b1;
      len_tab[0] = 4'd2;
      hit_tab[1] = 1'b1;
      len_tab[1] = 4'd15;
      start_job(13'd5);
      wait_done("t3_done");
      chk("t3_n_emit", n_emit, 2);
      chk("t3_copy0", {31'd0, e_copy[0]}, 32'd0);
      chk("t3_len0", {28'd0, e_len[0]}, 32'd0);
      chk("t3_pos1", {20'd0, e_pos[1]}, 32'd1);
      chk("t3_copy1", {31'd0, e_copy[1]}, 32'd1);
      chk("t3_len1", {28'd0, e_len[1]}, 32'd4);
      chk("t3_n_wr", n_wr, 2);
      chk("t3_ctrl_word", {16'd0, c_word[0]}, 32'h0002);

      // Twenty literals: two control words, stalled emit holds payload.
      clear_logs();
      emit_ready = 1'b0;
      start_job(13'd20);
      wait_emit_valid("t4_ev_seen");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", {31'd0, emit_valid}, 32'd1);
         chk("t4_hold_pos", {20'd0, pos}, 32'd0);
         chk("t4_hold_copy", {31'd0, emit_is_copy}, 32'd0);
         chk("t4_hold_len", {28'd0, emit_len}, 32'd0);
      end
      @(posedge clk); #1;
      emit_ready = 1'b1;
      wait_done("t4_done");
      chk("t4_n_emit", n_emit, 20);
      chk("t4_pos19", {20'd0, e_pos[19]}, 32'd19);
      chk("t4_n_ctrl", n_ctrl, 2);
      chk("t4_ctrl_at0", c_at[0], 16);
      chk("t4_ctrl_at1", c_at[1], 20);
      chk("t4_word0", {16'd0, c_word[0]}, 32'h0000);
      chk("t4_word1", {16'd0, c_word[1]}, 32'h0000);
      chk("t4_n_hash", n_hash, 18);

      // Empty job.
      clear_logs();
      start_job(13'd0);
      @(negedge clk);
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(negedge clk);
      chk("t5_n_emit", n_emit, 0);
      chk("t5_n_ctrl", n_ctrl, 0);

      // Reset during EMIT, restart, start while busy ignored.
      clear_logs();
      emit_ready = 1'b0;
      start_job(13'd8);
      wait_emit_valid("t6_ev_seen");
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, emit_valid}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_pos", {20'd0, pos}, 32'd0);
      chk("t6_rst_done", {31'd0, done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      emit_ready = 1'b1;
      clear_logs();
      start_job(13'd3);
      chk("t6_busy", {31'd0, busy}, 32'd1);
      src_len = 13'd9;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      wait_done("t6_done");
      chk("t6_n_emit", n_emit, 3);
      chk("t6_pos0", {20'd0, e_pos[0]}, 32'd0);
      chk("t6_pos2", {20'd0, e_pos[2]}, 32'd2);
      chk("t6_n_hash", n_hash, 1);
      chk("t6_n_ctrl", n_ctrl, 1);
      chk("t6_end_pos", {20'd0, pos}, 32'd3);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
